// File: rtl/conv_window_gen.sv
// conv_window_gen
// ---------------
// Streaming 3x3 sliding-window generator. Accepts Q8.8 pixels in raster
// order, keeps the two previous image rows in line buffers and, for every
// pixel that completes a full 3x3 neighbourhood (row >= 2, col >= 2), loads
// that window into a single output register. Valid (unpadded) convolution:
// (IMG_W-2)*(IMG_H-2) windows per frame, in raster order of the bottom-right
// pixel. Data is passed bit-exact.
//
// Optional feature macro: CONV_WIN_POS_EN
//   When defined, out_row/out_col carry the window centre coordinates
//   (bottom-right minus 1), registered alongside out_window.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   in_valid    in   in_pixel valid
//   in_ready    out  block can accept in_pixel this cycle
//   in_pixel    in   DATA_W pixel, raster order
//   out_valid   out  out_window valid
//   out_ready   in   downstream accepts out_window
//   out_window  out  9*DATA_W; element (r,c) at [DATA_W*(3*r+c) +: DATA_W],
//                    r=0 top row, c=0 left column
//   frame_done  out  one-cycle pulse after the last pixel of a frame is accepted
//   out_row     out  (CONV_WIN_POS_EN) window centre row
//   out_col     out  (CONV_WIN_POS_EN) window centre column
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Once out_valid is raised, out_window (and position) stay
// stable until out_ready is seen. in_ready = !out_valid || out_ready, so a
// new pixel is only taken when the output register is free or being emptied
// in the same cycle.
module conv_window_gen #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_pixel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [9*DATA_W-1:0]  out_window,
  output logic                 frame_done
`ifdef CONV_WIN_POS_EN
  ,
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic [$clog2(IMG_W)-1:0] out_col
`endif
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  // Position of the next pixel to be accepted
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  // Line buffers: lb0 holds the previous row, lb1 the row before that
  logic [DATA_W-1:0] r_lb0 [IMG_W];
  logic [DATA_W-1:0] r_lb1 [IMG_W];

  // Working 3x3 window, same packing as out_window
  logic [9*DATA_W-1:0] r_win;

  logic                r_out_valid;
  logic [9*DATA_W-1:0] r_out_window;
  logic                r_frame_done;

  logic                w_accept;
  logic                w_emit;
  logic                w_last;
  logic [9*DATA_W-1:0] w_next_win;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_emit     = w_accept && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
  assign w_last     = w_accept && (r_row == ROW_LAST) && (r_col == COL_LAST);

  assign out_valid  = r_out_valid;
  assign out_window = r_out_window;
  assign frame_done = r_frame_done;

  // Shift columns left; the new right column is {lb1, lb0, in_pixel}
  // top to bottom, read before this cycle's line-buffer write.
  always_comb begin
    w_next_win = '0;
    w_next_win[DATA_W*0 +: DATA_W] = r_win[DATA_W*1 +: DATA_W];
    w_next_win[DATA_W*1 +: DATA_W] = r_win[DATA_W*2 +: DATA_W];
    w_next_win[DATA_W*2 +: DATA_W] = r_lb1[r_col];
    w_next_win[DATA_W*3 +: DATA_W] = r_win[DATA_W*4 +: DATA_W];
    w_next_win[DATA_W*4 +: DATA_W] = r_win[DATA_W*5 +: DATA_W];
    w_next_win[DATA_W*5 +: DATA_W] = r_lb0[r_col];
    w_next_win[DATA_W*6 +: DATA_W] = r_win[DATA_W*7 +: DATA_W];
    w_next_win[DATA_W*7 +: DATA_W] = r_win[DATA_W*8 +: DATA_W];
    w_next_win[DATA_W*8 +: DATA_W] = in_pixel;
  end

  // Storage without reset: contents cannot reach the output before two
  // full rows have been written in the current frame.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[r_col] <= r_lb0[r_col];
      r_lb0[r_col] <= in_pixel;
      r_win        <= w_next_win;
    end
  end

  // Raster position counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Output register. Emit wins over consume, so a simultaneous consume and
  // emit keeps out_valid high with the new window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_window <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last;
      if (w_emit) begin
        r_out_valid  <= 1'b1;
        r_out_window <= w_next_win;
      end else if (out_ready) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

`ifdef CONV_WIN_POS_EN
  logic [ROW_W-1:0] r_out_row;
  logic [COL_W-1:0] r_out_col;

  assign out_row = r_out_row;
  assign out_col = r_out_col;

  // Centre of the window is one up and one left of the bottom-right pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_row <= '0;
      r_out_col <= '0;
    end else if (w_emit) begin
      r_out_row <= r_row - ROW_W'(1);
      r_out_col <= r_col - COL_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
`timescale 1ns/1ps
module tb_conv_window_gen;
  localparam int DW    = 16;
  localparam int WIN_W = 9*DW;
  localparam int SW = 4, SH = 4;
  localparam int LW = 28, LH = 28;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- small (4x4) instance ----------------
  logic             s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1, s_frame_done;
  logic [DW-1:0]    s_in_pixel = '0;
  logic [WIN_W-1:0] s_out_window;
`ifdef CONV_WIN_POS_EN
  logic [1:0] s_out_row, s_out_col;
`endif

  conv_window_gen #(.DATA_W(DW), .IMG_W(SW), .IMG_H(SH)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_pixel(s_in_pixel),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_window(s_out_window),
    .frame_done(s_frame_done)
`ifdef CONV_WIN_POS_EN
    , .out_row(s_out_row), .out_col(s_out_col)
`endif
  );

  // ---------------- large (28x28) instance ----------------
  logic             l_in_valid = 1'b0, l_in_ready, l_out_valid, l_out_ready = 1'b1, l_frame_done;
  logic [DW-1:0]    l_in_pixel = '0;
  logic [WIN_W-1:0] l_out_window;
`ifdef CONV_WIN_POS_EN
  logic [4:0] l_out_row, l_out_col;
`endif

  conv_window_gen #(.DATA_W(DW), .IMG_W(LW), .IMG_H(LH)) dut_l (
    .clk(clk), .rst(rst),
    .in_valid(l_in_valid), .in_ready(l_in_ready), .in_pixel(l_in_pixel),
    .out_valid(l_out_valid), .out_ready(l_out_ready), .out_window(l_out_window),
    .frame_done(l_frame_done)
`ifdef CONV_WIN_POS_EN
    , .out_row(l_out_row), .out_col(l_out_col)
`endif
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bad(input string name, input logic [WIN_W-1:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h, nothing expected here (t=%0t)", name, act, $time);
  endtask

  // Window literal from nine pixel indices k, each pixel k*256, (r,c) -> 3r+c
  function automatic logic [WIN_W-1:0] lit(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    int v[9];
    logic [WIN_W-1:0] w;
    v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    w = '0;
    for (int i = 0; i < 9; i++) w[DW*i +: DW] = DW'(v[i] * 256);
    return w;
  endfunction

  // ---------------- scoreboard: small instance ----------------
  // Model: remember every accepted pixel at its (row, col) in an image array;
  // a pixel at row>=2, col>=2 owes the 3x3 window above-left of it.
  logic [WIN_W-1:0] s_exp_q[$];
  logic [WIN_W-1:0] s_got[$];
  int               s_pos_q[$];
  logic [DW-1:0]    s_img[SW*SH];
  int               s_pix_idx = 0, s_fd_cnt = 0;
  logic             s_fd_exp = 1'b0;

  always @(negedge clk) begin : s_model
    int r, c;
    logic [WIN_W-1:0] w;
    chk("s_in_ready", WIN_W'(s_in_ready), WIN_W'(!s_out_valid || s_out_ready));
    chk("s_frame_done", WIN_W'(s_frame_done), WIN_W'(s_fd_exp));
    if (s_frame_done) s_fd_cnt++;
    if (s_out_valid) begin
      if (s_exp_q.size() == 0) bad("s_window_unexpected", s_out_window);
      else begin
        chk("s_window", s_out_window, s_exp_q[0]);
`ifdef CONV_WIN_POS_EN
        chk("s_pos", WIN_W'((int'(s_out_row) << 8) | int'(s_out_col)), WIN_W'(s_pos_q[0]));
`endif
      end
      if (s_out_ready) begin
        s_got.push_back(s_out_window);
        if (s_exp_q.size() != 0) begin
          void'(s_exp_q.pop_front());
          void'(s_pos_q.pop_front());
        end
      end
    end else begin
      chk("s_window_owed", WIN_W'(s_exp_q.size()), WIN_W'(0));
    end
    if (rst) begin
      s_exp_q.delete(); s_pos_q.delete();
      s_pix_idx = 0; s_fd_exp = 1'b0;
    end else begin
      s_fd_exp = 1'b0;
      if (s_in_valid && s_in_ready) begin
        r = s_pix_idx / SW; c = s_pix_idx % SW;
        s_img[s_pix_idx] = s_in_pixel;
        if (r >= 2 && c >= 2) begin
          for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
              w[DW*(3*rr+cc) +: DW] = s_img[(r-2+rr)*SW + (c-2+cc)];
          s_exp_q.push_back(w);
          s_pos_q.push_back(((r-1) << 8) | (c-1));
        end
        s_fd_exp  = (s_pix_idx == SW*SH-1);
        s_pix_idx = (s_pix_idx + 1) % (SW*SH);
      end
    end
  end

  // ---------------- scoreboard: large instance ----------------
  logic [WIN_W-1:0] l_exp_q[$];
  int               l_pos_q[$];
  logic [DW-1:0]    l_img[LW*LH];
  int               l_pix_idx = 0, l_fd_cnt = 0, l_got_cnt = 0;
  logic             l_fd_exp = 1'b0;

  always @(negedge clk) begin : l_model
    int r, c;
    logic [WIN_W-1:0] w;
    chk("l_in_ready", WIN_W'(l_in_ready), WIN_W'(!l_out_valid || l_out_ready));
    chk("l_frame_done", WIN_W'(l_frame_done), WIN_W'(l_fd_exp));
    if (l_frame_done) l_fd_cnt++;
    if (l_out_valid) begin
      if (l_exp_q.size() == 0) bad("l_window_unexpected", l_out_window);
      else begin
        chk("l_window", l_out_window, l_exp_q[0]);
`ifdef CONV_WIN_POS_EN
        chk("l_pos", WIN_W'((int'(l_out_row) << 8) | int'(l_out_col)), WIN_W'(l_pos_q[0]));
`endif
      end
      if (l_out_ready) begin
        l_got_cnt++;
        if (l_exp_q.size() != 0) begin
          void'(l_exp_q.pop_front());
          void'(l_pos_q.pop_front());
        end
      end
    end else begin
      chk("l_window_owed", WIN_W'(l_exp_q.size()), WIN_W'(0));
    end
    if (rst) begin
      l_exp_q.delete(); l_pos_q.delete();
      l_pix_idx = 0; l_fd_exp = 1'b0;
    end else begin
      l_fd_exp = 1'b0;
      if (l_in_valid && l_in_ready) begin
        r = l_pix_idx / LW; c = l_pix_idx % LW;
        l_img[l_pix_idx] = l_in_pixel;
        if (r >= 2 && c >= 2) begin
          for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
              w[DW*(3*rr+cc) +: DW] = l_img[(r-2+rr)*LW + (c-2+cc)];
          l_exp_q.push_back(w);
          l_pos_q.push_back(((r-1) << 8) | (c-1));
        end
        l_fd_exp  = (l_pix_idx == LW*LH-1);
        l_pix_idx = (l_pix_idx + 1) % (LW*LH);
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present a pixel and hold it until accepted; in_valid stays high so
  // consecutive calls stream without gaps.
  task automatic send_s(input logic [DW-1:0] pix);
    bit done = 1'b0;
    int n = 0;
    s_in_valid = 1'b1; s_in_pixel = pix;
    while (!done && n < 200) begin
      @(negedge clk); done = s_in_ready;
      @(posedge clk); #1; n++;
    end
    if (!done) bad("s_send_timeout", WIN_W'(pix));
  endtask

  task automatic send_l(input logic [DW-1:0] pix);
    bit done = 1'b0;
    int n = 0;
    l_in_valid = 1'b1; l_in_pixel = pix;
    while (!done && n < 200) begin
      @(negedge clk); done = l_in_ready;
      @(posedge clk); #1; n++;
    end
    if (!done) bad("l_send_timeout", WIN_W'(pix));
  endtask

  task automatic frame_s(input int first, input int count);
    for (int k = first; k < first + count; k++) send_s(DW'(k * 256));
    s_in_valid = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++; checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  bit l_run = 1'b0;

  initial begin
    int t0;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_s_out_valid",  WIN_W'(s_out_valid), WIN_W'(0));
    chk("rst_s_out_window", s_out_window, WIN_W'(0));
    chk("rst_s_frame_done", WIN_W'(s_frame_done), WIN_W'(0));
    chk("rst_s_in_ready",   WIN_W'(s_in_ready), WIN_W'(1));
    chk("rst_l_out_valid",  WIN_W'(l_out_valid), WIN_W'(0));
    chk("rst_l_in_ready",   WIN_W'(l_in_ready), WIN_W'(1));
    @(posedge clk); #1;

    // Basic order, no backpressure: one pixel per cycle
    s_got.delete(); s_fd_cnt = 0;
    t0 = cyc;
    frame_s(0, 16);
    chk("basic_cycles", WIN_W'(cyc - t0), WIN_W'(16));
    step(3);
    chk("basic_count",  WIN_W'(s_got.size()), WIN_W'(4));
    chk("basic_first",  s_got[0], lit(0, 1, 2, 4, 5, 6, 8, 9, 10));
    chk("basic_second", s_got[1], lit(1, 2, 3, 5, 6, 7, 9, 10, 11));
    chk("basic_last",   s_got[3], lit(5, 6, 7, 9, 10, 11, 13, 14, 15));
    chk("basic_fd_cnt", WIN_W'(s_fd_cnt), WIN_W'(1));

    // Backpressure: stall window 2 for three cycles
    s_got.delete(); s_fd_cnt = 0;
    fork
      frame_s(0, 16);
      begin : stall
        int n = 0;
        logic [WIN_W-1:0] held;
        while (!(s_out_valid && s_got.size() == 1) && n < 100) begin
          @(posedge clk); #1; n++;
        end
        if (n >= 100) bad("bp_wait_timeout", WIN_W'(n));
        s_out_ready = 1'b0;
        held = s_out_window;
        chk("bp_held_literal", held, lit(1, 2, 3, 5, 6, 7, 9, 10, 11));
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready_low", WIN_W'(s_in_ready), WIN_W'(0));
          chk("bp_valid_held",   WIN_W'(s_out_valid), WIN_W'(1));
          chk("bp_window_held",  s_out_window, held);
          @(posedge clk); #1;
        end
        s_out_ready = 1'b1;
      end
    join
    step(3);
    chk("bp_count",  WIN_W'(s_got.size()), WIN_W'(4));
    chk("bp_first",  s_got[0], lit(0, 1, 2, 4, 5, 6, 8, 9, 10));
    chk("bp_last",   s_got[3], lit(5, 6, 7, 9, 10, 11, 13, 14, 15));
    chk("bp_fd_cnt", WIN_W'(s_fd_cnt), WIN_W'(1));

    // Back-to-back frames, second frame values +16
    s_got.delete(); s_fd_cnt = 0;
    frame_s(0, 32);
    step(3);
    chk("b2b_count",      WIN_W'(s_got.size()), WIN_W'(8));
    chk("b2b_f2_first",   s_got[4], lit(16, 17, 18, 20, 21, 22, 24, 25, 26));
    chk("b2b_f2_last",    s_got[7], lit(21, 22, 23, 25, 26, 27, 29, 30, 31));
    chk("b2b_fd_cnt",     WIN_W'(s_fd_cnt), WIN_W'(2));

    // Reset mid-frame after 9 pixels, then a full frame
    frame_s(100, 9);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_out_valid",  WIN_W'(s_out_valid), WIN_W'(0));
    chk("rstmid_frame_done", WIN_W'(s_frame_done), WIN_W'(0));
    @(posedge clk); #1;
    s_got.delete(); s_fd_cnt = 0;
    frame_s(0, 16);
    step(3);
    chk("rstmid_count",  WIN_W'(s_got.size()), WIN_W'(4));
    chk("rstmid_first",  s_got[0], lit(0, 1, 2, 4, 5, 6, 8, 9, 10));
    chk("rstmid_last",   s_got[3], lit(5, 6, 7, 9, 10, 11, 13, 14, 15));
    chk("rstmid_fd_cnt", WIN_W'(s_fd_cnt), WIN_W'(1));

    // 28x28 with random valid/ready throttling
    l_got_cnt = 0; l_fd_cnt = 0; l_run = 1'b1;
    fork
      begin : feeder
        for (int k = 0; k < LW*LH; k++) begin
          send_l(DW'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            l_in_valid = 1'b0;
            step($urandom_range(1, 2));
          end
        end
        l_in_valid = 1'b0;
        l_run = 1'b0;
      end
      begin : throttle
        while (l_run) begin
          l_out_ready = ($urandom_range(0, 3) != 0);
          step(1);
        end
        l_out_ready = 1'b1;
      end
    join
    step(4);
    chk("rand_count",  WIN_W'(l_got_cnt), WIN_W'(676));
    chk("rand_fd_cnt", WIN_W'(l_fd_cnt), WIN_W'(1));
    chk("rand_drained", WIN_W'(l_exp_q.size()), WIN_W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3 sliding-window generator sitting directly downstream of the pixel normalizer. It accepts normalized Q8.8 pixels in raster order and buffers two image rows in line buffers. For every position where a full 3x3 neighbourhood exists, it emits that window to the convolution engine. Valid (unpadded) convolution only, with one output register and valid/ready backpressure on both sides.

## Interface
- DATA_W, 16, pixel width (Q8.8 from normalizer)
- IMG_W, 28, image width in pixels (>= 3)
- IMG_H, 28, image height in rows (>= 3)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_pixel valid
- in_ready  out  1  block can accept in_pixel this cycle
- in_pixel  in  DATA_W  normalized pixel, raster order
- out_valid  out  1  out_window valid
- out_ready  in  1  downstream accepts out_window
- out_window  out  9*DATA_W  window; element (r,c) at [DATA_W*(3*r+c) +: DATA_W], r=0 top row, c=0 left column
- frame_done  out  1  one-cycle pulse, last pixel of frame accepted

## Operation
- Input handshake: pixel accepted when in_valid && in_ready. Output handshake: window consumed when out_valid && out_ready.
- in_ready = !out_valid || out_ready (combinational). No input acceptance while the output register holds an unconsumed window.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) track the position of the next accepted pixel. col wraps to 0 and row increments at IMG_W-1. Both wrap to 0 after (IMG_H-1, IMG_W-1).
- Two line buffers, each IMG_W x DATA_W, indexed by col. On accept: lb1[col] <= lb0[col]; lb0[col] <= in_pixel. The column read before the write supplies the upper two window rows.
- Window shift register 3x3: on accept, columns shift left. The new right column is {lb1[col], lb0[col], in_pixel} (top to bottom).
- Emit condition: accepted pixel has row >= 2 and col >= 2. out_window is loaded and out_valid is set on the next edge. Otherwise out_valid clears if consumed.
- Windows per frame: (IMG_W-2)*(IMG_H-2), emitted in raster order of their bottom-right pixel.
- Data is passed bit-exact; no arithmetic.
- Line-buffer and window contents are not reset. They cannot reach the output before being overwritten, because the emit condition requires two fully written rows.

## Timing
- Reset values: out_valid=0, out_window=0, frame_done=0, row=0, col=0. in_ready=1 in the first cycle after reset.
- Latency: window with bottom-right pixel P is valid on the cycle after P is accepted.
- Throughput: one pixel per cycle while out_ready=1.
- Backpressure: out_window and out_valid stay stable while out_valid && !out_ready. in_ready is low during this time.
- Simultaneous events: consume and emit in the same cycle loads the new window with out_valid held at 1.
- frame_done: high the cycle after the pixel at (IMG_H-1, IMG_W-1) is accepted. Coincides with out_valid of the last window.
- Next frame may start the following cycle; row-0/1 pixels of the new frame produce no output.
- rst mid-frame: a pending window is dropped, counters return to 0, and the next accepted pixel is treated as (0,0).

## Configuration
- CONV_WIN_POS_EN defined: adds ports out_row and out_col (out, clog2(IMG_H) / clog2(IMG_W)).
  - These give the window centre coordinates: bottom-right minus 1.
  - They are registered with out_window, share its backpressure stability, and reset to 0.
- Not defined: ports absent; no position registers.

## Test plan
- Basic order: IMG_W=4, IMG_H=4, pixels k*256 for k=0..15, no backpressure.
  - Exactly 4 windows.
  - First one the cycle after k=10 is accepted: {0,1,2,4,5,6,8,9,10}*256.
  - Last is {5,6,7,9,10,11,13,14,15}*256.
  - frame_done together with the last window.
- Backpressure: same stream, out_ready low for 3 cycles while window 2 is valid.
  - Window 2 is held stable and in_ready=0 during the stall.
  - No pixel is lost; all 4 windows are correct.
- Back-to-back frames: two 4x4 frames with no gap, second frame values +16.
  - 8 windows; the first window of frame 2 contains only frame-2 pixels.
  - Two frame_done pulses.
- Reset mid-frame: assert rst after 9 pixels, then send a full frame.
  - out_valid=0 in the cycle after reset.
  - Exactly 4 windows, matching the basic-order case.
- Random valid/ready throttling at 28x28 against a software model: 676 windows, bit-exact.
- With CONV_WIN_POS_EN at 4x4: out_row/out_col equal (1,1), (1,2), (2,1), (2,2).
